// File: rtl/datapath_dump_ctrl_pkg.sv
// Shared types for the end-of-run dump controller: FSM states, stream tags,
// halt causes and the stream beat record.
package dump_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DUMP_REG = 2'd1,
    ST_DUMP_MEM = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  localparam logic [1:0] TAG_PC  = 2'd0;
  localparam logic [1:0] TAG_REG = 2'd1;
  localparam logic [1:0] TAG_MEM = 2'd2;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ZERO    = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  typedef struct packed {
    logic [1:0]  tag;
    logic [31:0] data;
  } beat_t;

  // A zero instruction outranks a timeout landing on the same cycle.
  function automatic logic [1:0] halt_cause(input logic zero_inst, input logic expired);
    if (zero_inst)    return CAUSE_ZERO;
    else if (expired) return CAUSE_TIMEOUT;
    else              return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/datapath_dump_ctrl_if.sv
// Core-side probe/read ports plus the tagged output stream of the dump controller.
interface datapath_dump_ctrl_if #(
  parameter int NUM_REGS = 32
);
  localparam int RA_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [31:0]     pc;
  logic [31:0]     inst;
  logic [RA_W-1:0] rf_raddr;
  logic [31:0]     rf_rdata;
  logic [31:0]     mem_raddr;
  logic [31:0]     mem_rdata;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_data;
  logic [1:0]      out_tag;

  modport master (
    input  pc, inst, rf_rdata, mem_rdata, out_ready,
    output rf_raddr, mem_raddr, out_valid, out_data, out_tag
  );

  modport slave (
    output pc, inst, rf_rdata, mem_rdata, out_ready,
    input  rf_raddr, mem_raddr, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/datapath_dump_ctrl_cycle_timer.sv
// RUN-phase cycle counter; expired flags the last allowed cycle (count == TIMEOUT-1).
module dump_cycle_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic expired
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  assign expired = (count == CW'(TIMEOUT - 1));

  // Only reset clears the count; it freezes at expiry so it never wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               count <= '0;
    else if (en && !expired)  count <= count + CW'(1);
  end
endmodule

// File: rtl/datapath_dump_ctrl.sv
// End-of-run monitor: detects halt, then streams the register file and a memory window.
// Optional PC trace during RUN is enabled with `define DUMP_PC_TRACE_EN.
module datapath_dump_ctrl
  import dump_pkg::*;
#(
  parameter int          NUM_REGS  = 32,
  parameter logic [31:0] MEM_BASE  = 32'h4000,
  parameter int          MEM_WORDS = 4,
  parameter int          TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  datapath_dump_ctrl_if.master bus,
  output logic                 halted,
  output logic [1:0]           cause,
  output logic                 done
`ifdef DUMP_PC_TRACE_EN
  ,output logic                trace_drop
`endif
);
  localparam int          RA_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [31:0] REG_LAST = 32'(NUM_REGS - 1);
  localparam logic [31:0] MEM_LAST = 32'(MEM_WORDS - 1);

  state_t      state;
  logic [31:0] idx;
  logic        expired;
  logic        zero_inst;
  logic        valid;
  logic        fire;
  beat_t       beat;

  dump_cycle_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .en      (state == ST_RUN),
    .expired (expired)
  );

  assign zero_inst = (bus.inst == 32'd0);
  assign fire      = valid && bus.out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_RUN;
      idx    <= '0;
      halted <= 1'b0;
      cause  <= CAUSE_NONE;
      done   <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (zero_inst || expired) begin
            state  <= ST_DUMP_REG;
            idx    <= '0;
            halted <= 1'b1;
            cause  <= halt_cause(zero_inst, expired);
          end
        end
        ST_DUMP_REG: begin
          if (fire) begin
            if (idx == REG_LAST) begin
              state <= ST_DUMP_MEM;
              idx   <= '0;
            end else begin
              idx   <= idx + 32'd1;
            end
          end
        end
        ST_DUMP_MEM: begin
          if (fire) begin
            if (idx == MEM_LAST) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              idx   <= idx + 32'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Read addresses track idx directly; since idx only moves on a handshake,
  // the combinational read data (and so the beat) is stable while stalled.
  assign bus.rf_raddr  = (state == ST_DUMP_REG) ? idx[RA_W-1:0] : '0;
  assign bus.mem_raddr = MEM_BASE + ((state == ST_DUMP_MEM) ? idx : 32'd0);

  always_comb begin
    valid = 1'b0;
    beat  = '0;
    case (state)
      ST_DUMP_REG: begin
        valid     = 1'b1;
        beat.tag  = TAG_REG;
        beat.data = bus.rf_rdata;
      end
      ST_DUMP_MEM: begin
        valid     = 1'b1;
        beat.tag  = TAG_MEM;
        beat.data = bus.mem_rdata;
      end
`ifdef DUMP_PC_TRACE_EN
      ST_RUN: begin
        // Gated by reset so the stream reads idle while reset is held.
        valid     = reset;
        beat.tag  = TAG_PC;
        beat.data = reset ? bus.pc : 32'd0;
      end
`endif
      default: ;
    endcase
  end

  assign bus.out_valid = valid;
  assign bus.out_tag   = beat.tag;
  assign bus.out_data  = beat.data;

`ifdef DUMP_PC_TRACE_EN
  // Trace has no backpressure: any RUN cycle without ready loses its word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                trace_drop <= 1'b0;
    else if (state == ST_RUN && !bus.out_ready) trace_drop <= 1'b1;
  end
`else
  logic unused_pc;
  assign unused_pc = ^bus.pc;
`endif

endmodule

// File: doc/datapath_dump_ctrl.md
# datapath_dump_ctrl

Synthesizable end-of-run monitor for the datapath autograder harness. Watches the core's PC and fetched instruction; detects halt (all-zero instruction) or a cycle timeout; then sequences a dump of the register file and a configurable data-memory window through the core's read ports, emitting tagged words on a valid/ready stream. Sits beside `machine`, replacing hard-coded bench dump loops and fixed run-time limits.

## Interface
Parameters:
- `NUM_REGS`, 32: register-file entries dumped (indices 0..NUM_REGS-1)
- `MEM_BASE`, 32'h4000: first data-memory word index dumped
- `MEM_WORDS`, 4: number of memory words dumped (≥1)
- `TIMEOUT`, 64: max RUN cycles before forced halt (≥1)

Ports:
- `clk` in 1: clock, rising edge
- `reset` in 1: **asynchronous, active-low** reset
- `pc` in 32: current byte PC of core
- `inst` in 32: instruction fetched this cycle
- `rf_raddr` out $clog2(NUM_REGS): register read address
- `rf_rdata` in 32: combinational register read data
- `mem_raddr` out 32: data-memory word index
- `mem_rdata` in 32: combinational memory read data
- `out_valid` out 1 / `out_ready` in 1: output stream handshake
- `out_data` out 32: stream word
- `out_tag` out 2: 0 = PC trace, 1 = register, 2 = memory
- `halted` out 1: RUN has ended (sticky)
- `cause` out 2: 0 none, 1 zero instruction, 2 timeout
- `done` out 1: dump complete (sticky)

## Operation
- States: RUN → DUMP_REG → DUMP_MEM → DONE.
- RUN: cycle counter increments each clock. Halt when `inst == 0` (cause 1) or counter == TIMEOUT-1 (cause 2). Both in same cycle → cause 1. Halt cycle's transition → DUMP_REG, `halted`=1, `cause` latched.
- DUMP_REG: index idx from 0; `rf_raddr`=idx; `out_valid`=1, `out_tag`=1, `out_data`=`rf_rdata`. On `out_valid && out_ready`, idx++; after idx NUM_REGS-1 accepted → DUMP_MEM, idx=0.
- DUMP_MEM: `mem_raddr`=MEM_BASE+idx, tag 2, `out_data`=`mem_rdata`; advance as above; after MEM_WORDS-1 accepted → DONE.
- DONE: `out_valid`=0, `done`=1; terminal until reset. `pc`, `inst` ignored after RUN.
- Stream rule: `out_valid` never drops and `out_tag`/`out_data` never change while `out_valid && !out_ready` (idx advances only on handshake; read ports combinational).
- MEM_BASE+idx computed in 32 bits, wraps modulo 2^32.

## Timing
- Reset (async assert, sync release): state RUN, counter 0, idx 0, `out_valid` 0, `out_data` 0, `out_tag` 0, `halted` 0, `cause` 0, `done` 0, `rf_raddr` 0, `mem_raddr` MEM_BASE.
- Halt detection: 1 cycle; first dump word valid in cycle after halt edge.
- With `out_ready` held 1: NUM_REGS + MEM_WORDS cycles of dump, then `done` next cycle.
- Reset asserted mid-dump aborts immediately; restart in RUN with counter 0.
- TIMEOUT=1: halts at first edge after reset release (cause 2 unless `inst`==0).

## Configuration
- `DUMP_PC_TRACE_EN` defined: in RUN, each cycle `out_valid`=1, tag 0, `out_data`=`pc`. No backpressure on trace: word not accepted is dropped; sticky `trace_drop` bit (extra 1-bit output, reset 0) set on any RUN cycle with `out_ready`=0. Halt cycle emits its PC too.
- Not defined: `out_valid`=0 throughout RUN; `trace_drop` port absent.

## Structure
- Package `dump_pkg`: state enum, tag constants (TAG_PC/TAG_REG/TAG_MEM), cause constants (CAUSE_NONE/ZERO/TIMEOUT).
- One sub-module: `dump_cycle_timer` (TIMEOUT-parameterised counter, `expired` output, clear on reset only).

## Test plan
- Zero inst at RUN cycle 5, `out_ready`=1 → `halted`=1 cause 1; 32 tag-1 words matching r[0..31], then 4 tag-2 words from 0x4000..0x4003, `done` after 36 dump cycles.
- `inst` never 0, TIMEOUT=64 → halt at counter 63, cause 2, same dump sequence.
- Zero inst coincident with timeout cycle → cause 1.
- Dump with `out_ready` toggling 1-0-0-1 → `out_data`/`out_tag` stable while stalled; no word skipped or duplicated.
- Reset pulsed low during DUMP_MEM idx 2 → all outputs to reset values immediately; full run/dump repeats cleanly.
- `DUMP_PC_TRACE_EN`, PC 0x00400000 stepping +4, `out_ready`=0 for one RUN cycle → tag-0 words equal PC, `trace_drop`=1 sticky.
